// File: rtl/lfsr_prbs_test_pkg.sv
// Shared definitions for the PRBS test sequencer: FSM state encoding and
// the popcount helper used by the error accumulator.
package lfsr_prbs_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Widest error vector the popcount helper accepts, and its result width.
    localparam int POP_IN_W  = 512;
    localparam int POP_OUT_W = 16;

    // Number of set bits in v; narrower callers zero-extend into v.
    function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
        logic [POP_OUT_W-1:0] c;
        c = 16'd0;
        for (int i = 0; i < POP_IN_W; i++) begin
            c = c + {15'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_err_accum.sv
// Bit-error accumulator: on each valid cycle adds popcount(check_err) to a
// saturating counter, after skipping the first LOCK_WORDS valid cycles
// while the checker self-synchronises.
module prbs_err_accum
    import lfsr_prbs_test_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ERR_WIDTH  = 32,
    parameter int LOCK_WORDS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  err_valid,
    input  logic [DATA_WIDTH-1:0] check_err,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam int LOCK_W = (LOCK_WORDS < 1) ? 1 : $clog2(LOCK_WORDS + 1);
    localparam int SUM_W  = ERR_WIDTH + POP_OUT_W;

    logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
    logic [POP_OUT_W-1:0] pop_s;
    logic [SUM_W-1:0]     sum_s;
    logic                 in_lock_s;

    // Next-state: clear on test start, skip lock words, then saturating add.
    always_comb begin
        lock_cnt_d  = lock_cnt_q;
        err_count_d = err_count_q;
        pop_s       = popcount(POP_IN_W'(check_err));
        sum_s       = SUM_W'(err_count_q) + SUM_W'(pop_s);
        in_lock_s   = (lock_cnt_q < LOCK_W'(LOCK_WORDS));
        if (clr) begin
            lock_cnt_d  = {LOCK_W{1'b0}};
            err_count_d = {ERR_WIDTH{1'b0}};
        end else if (err_valid) begin
            if (in_lock_s) begin
                lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end else if (|sum_s[SUM_W-1:ERR_WIDTH]) begin
                err_count_d = {ERR_WIDTH{1'b1}};
            end else begin
                err_count_d = sum_s[ERR_WIDTH-1:0];
            end
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q  <= {LOCK_W{1'b0}};
            err_count_q <= {ERR_WIDTH{1'b0}};
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: rtl/lfsr_prbs_test_ctrl.sv
// PRBS link test sequencer: resets generator and checker, runs the
// generator for word_count words, enables the checker after the data path
// latency, drains the pipe and reports busy/done/aborted/error status.
// All outputs come straight from flops; they lag the FSM state by a cycle.
module lfsr_prbs_test_ctrl
    import lfsr_prbs_test_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int COUNT_WIDTH  = 32,
    parameter int ERR_WIDTH    = 32,
    parameter int PIPE_LATENCY = 1,
    parameter int LOCK_WORDS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   prbs_rst,
    output logic                   prbs_enable,
    output logic                   check_rst,
    output logic                   check_enable,
    input  logic [DATA_WIDTH-1:0]  check_err,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [ERR_WIDTH-1:0]   err_count,
    output logic [COUNT_WIDTH-1:0] words_done
);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [3:0]             drain_q, drain_d;
    logic [PIPE_LATENCY:0]  en_pipe_q, en_pipe_d;
    logic                   err_valid_q, err_valid_d;
    logic                   prbs_rst_q, prbs_rst_d;
    logic                   check_rst_q, check_rst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic [COUNT_WIDTH-1:0] words_done_q, words_done_d;

    logic busy_state_s;
    logic abort_hit_s;
    logic start_ok_s;
    logic issue_s;
    logic acc_valid_s;

    // Qualify start/abort against the current state; abort beats start in IDLE.
    always_comb begin
        busy_state_s = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
        abort_hit_s  = abort && busy_state_s;
        start_ok_s   = (state_q == ST_IDLE) && start && !abort;
        acc_valid_s  = err_valid_q && !abort_hit_s;
    end

    // FSM next-state, word/drain counters and registered output values.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        drain_d      = drain_q;
        words_done_d = words_done_q;
        aborted_d    = aborted_q;
        issue_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d      = ST_INIT;
                    remaining_d  = word_count;
                    words_done_d = {COUNT_WIDTH{1'b0}};
                    aborted_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (remaining_q == {COUNT_WIDTH{1'b0}}) begin
                    state_d = ST_DRAIN;
                    drain_d = 4'(PIPE_LATENCY);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                issue_s      = 1'b1;
                words_done_d = words_done_q + COUNT_WIDTH'(1);
                remaining_d  = remaining_q - COUNT_WIDTH'(1);
                if (remaining_q == COUNT_WIDTH'(1)) begin
                    state_d = ST_DRAIN;
                    drain_d = 4'(PIPE_LATENCY);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Entered with PIPE_LATENCY, so the state lasts PIPE_LATENCY+1 cycles.
                if (drain_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided; counters hold.
        if (abort_hit_s) begin
            state_d      = ST_IDLE;
            issue_s      = 1'b0;
            words_done_d = words_done_q;
            aborted_d    = 1'b1;
        end else begin
            aborted_d = aborted_d;
        end

        prbs_rst_d  = (state_q == ST_INIT) && !abort_hit_s;
        check_rst_d = (state_q == ST_INIT) && !abort_hit_s;
        busy_d      = busy_state_s && !abort_hit_s;
        done_d      = (state_q == ST_DONE);

        // Bit 0 drives the generator; bit PIPE_LATENCY drives the checker.
        en_pipe_d[0] = issue_s;
        for (int i = 1; i <= PIPE_LATENCY; i++) begin
            en_pipe_d[i] = en_pipe_q[i-1];
        end
        err_valid_d = en_pipe_q[PIPE_LATENCY];
        if (abort_hit_s) begin
            en_pipe_d   = {(PIPE_LATENCY+1){1'b0}};
            err_valid_d = 1'b0;
        end else begin
            err_valid_d = err_valid_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= {COUNT_WIDTH{1'b0}};
            drain_q      <= 4'd0;
            en_pipe_q    <= {(PIPE_LATENCY+1){1'b0}};
            err_valid_q  <= 1'b0;
            prbs_rst_q   <= 1'b0;
            check_rst_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            words_done_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            drain_q      <= drain_d;
            en_pipe_q    <= en_pipe_d;
            err_valid_q  <= err_valid_d;
            prbs_rst_q   <= prbs_rst_d;
            check_rst_q  <= check_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            words_done_q <= words_done_d;
        end
    end

    prbs_err_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_WIDTH  (ERR_WIDTH),
        .LOCK_WORDS (LOCK_WORDS)
    ) u_err_accum (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok_s),
        .err_valid (acc_valid_s),
        .check_err (check_err),
        .err_count (err_count)
    );

    assign prbs_rst     = prbs_rst_q;
    assign check_rst    = check_rst_q;
    assign prbs_enable  = en_pipe_q[0];
    assign check_enable = en_pipe_q[PIPE_LATENCY];
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign words_done   = words_done_q;

endmodule

// File: tb/tb_lfsr_prbs_test_ctrl.sv
// Directed bench for lfsr_prbs_test_ctrl: a table of complete runs with
// hand-computed timing and error counts, plus sequences for abort, start
// while busy, start+abort in IDLE and reset during DRAIN. A second
// instance with a 4-bit error counter exercises saturation.
module tb_lfsr_prbs_test_ctrl;

    localparam int P = 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] word_count;
    logic [63:0] check_err;
    logic [63:0] check_err2;

    logic        prbs_rst, prbs_enable, check_rst, check_enable;
    logic        busy, done, aborted;
    logic [31:0] err_count, words_done;

    logic        prbs_rst2, prbs_enable2, check_rst2, check_enable2;
    logic        busy2, done2, aborted2;
    logic [3:0]  err_count2;
    logic [31:0] words_done2;

    int tests;
    int fails;

    lfsr_prbs_test_ctrl #(
        .DATA_WIDTH(64), .COUNT_WIDTH(32), .ERR_WIDTH(32), .PIPE_LATENCY(P), .LOCK_WORDS(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .word_count(word_count),
        .prbs_rst(prbs_rst), .prbs_enable(prbs_enable), .check_rst(check_rst),
        .check_enable(check_enable), .check_err(check_err), .busy(busy), .done(done),
        .aborted(aborted), .err_count(err_count), .words_done(words_done)
    );

    lfsr_prbs_test_ctrl #(
        .DATA_WIDTH(64), .COUNT_WIDTH(32), .ERR_WIDTH(4), .PIPE_LATENCY(P), .LOCK_WORDS(1)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .word_count(word_count),
        .prbs_rst(prbs_rst2), .prbs_enable(prbs_enable2), .check_rst(check_rst2),
        .check_enable(check_enable2), .check_err(check_err2), .busy(busy2), .done(done2),
        .aborted(aborted2), .err_count(err_count2), .words_done(words_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        int          v1;
        logic [63:0] e1;
        int          v2;
        logic [63:0] e2;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a start pulse sampled at the next rising edge (relative cycle 0).
    task automatic start_test(input int n);
        @(negedge clk);
        word_count = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done starting from relative cycle rel0; at = -1 on timeout.
    task automatic wait_done(input int rel0, output int at);
        at = -1;
        for (int rel = rel0; rel < 80; rel++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = rel;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int at, rst_cnt, rst_first, pe_cnt, pe_first, ce_cnt, ce_first, busy_cnt, k;
        int exp_first_pe, exp_first_ce, exp_sat, seen_done;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        word_count = 32'd0;
        check_err = 64'd0;
        check_err2 = {64{1'b1}};

        vecs[0] = '{n: 4, v1: -1, e1: 64'h0, v2: -1, e2: 64'h0, exp_err: 0};
        vecs[1] = '{n: 8, v1: 1, e1: 64'h1, v2: 3, e2: 64'hFF, exp_err: 8};
        vecs[2] = '{n: 0, v1: -1, e1: 64'h0, v2: -1, e2: 64'h0, exp_err: 0};
        vecs[3] = '{n: 3, v1: 2, e1: 64'hF0F0, v2: 3, e2: 64'h8000_0000_0000_0001, exp_err: 10};
        vecs[4] = '{n: 2, v1: 1, e1: {64{1'b1}}, v2: 2, e2: 64'h3, exp_err: 2};
        vecs[5] = '{n: 5, v1: 0, e1: {64{1'b1}}, v2: 6, e2: {64{1'b1}}, exp_err: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_prbs_enable", prbs_enable, 0);
        chk("rst_check_enable", check_enable, 0);
        chk("rst_prbs_rst", prbs_rst, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_words_done", words_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table of complete runs.
        for (int i = 0; i < 6; i++) begin
            start_test(vecs[i].n);
            at = -1; rst_cnt = 0; rst_first = -1; pe_cnt = 0; pe_first = -1;
            ce_cnt = 0; ce_first = -1; busy_cnt = 0;
            for (int rel = 0; rel < 60; rel++) begin
                k = rel - (3 + P) + 1;
                if (k == vecs[i].v1) check_err = vecs[i].e1;
                else if (k == vecs[i].v2) check_err = vecs[i].e2;
                else check_err = 64'd0;
                @(negedge clk);
                if (prbs_rst && check_rst) begin
                    rst_cnt++;
                    if (rst_first < 0) rst_first = rel;
                end
                if (prbs_enable) begin
                    pe_cnt++;
                    if (pe_first < 0) pe_first = rel;
                end
                if (check_enable) begin
                    ce_cnt++;
                    if (ce_first < 0) ce_first = rel;
                end
                if (busy) busy_cnt++;
                if (done) begin
                    at = rel;
                    break;
                end
                @(posedge clk);
                #1;
            end
            exp_first_pe = (vecs[i].n > 0) ? 2 : -1;
            exp_first_ce = (vecs[i].n > 0) ? 2 + P : -1;
            chk($sformatf("v%0d_done_at", i), at, 3 + vecs[i].n + P);
            chk($sformatf("v%0d_rst_cnt", i), rst_cnt, 1);
            chk($sformatf("v%0d_rst_first", i), rst_first, 1);
            chk($sformatf("v%0d_pe_cnt", i), pe_cnt, vecs[i].n);
            chk($sformatf("v%0d_pe_first", i), pe_first, exp_first_pe);
            chk($sformatf("v%0d_ce_cnt", i), ce_cnt, vecs[i].n);
            chk($sformatf("v%0d_ce_first", i), ce_first, exp_first_ce);
            chk($sformatf("v%0d_busy_cnt", i), busy_cnt, vecs[i].n + P + 2);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            chk($sformatf("v%0d_words_done", i), words_done, vecs[i].n);
            chk($sformatf("v%0d_err_at_done", i), err_count, vecs[i].exp_err);
            @(posedge clk);
            #1 check_err = 64'd0;
            @(negedge clk);
            chk($sformatf("v%0d_err_after", i), err_count, vecs[i].exp_err);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_aborted", i), aborted, 0);
            exp_sat = (vecs[i].n <= 1) ? 0 : ((64 * (vecs[i].n - 1) > 15) ? 15 : 64 * (vecs[i].n - 1));
            chk($sformatf("v%0d_sat_err", i), err_count2, exp_sat);
        end

        // Abort at word 3 of 10, then a normal run clears aborted.
        start_test(10);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_pre_words", words_done, 3);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_aborted", aborted, 1);
        chk("abort_done", done, 0);
        chk("abort_words", words_done, 3);
        chk("abort_prbs_enable", prbs_enable, 0);
        chk("abort_check_enable", check_enable, 0);
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || prbs_enable || check_enable) seen_done = 1;
        end
        chk("abort_quiet", seen_done, 0);
        chk("abort_words_hold", words_done, 3);
        start_test(2);
        wait_done(0, at);
        chk("rerun_done_at", at, 3 + 2 + P);
        chk("rerun_aborted", aborted, 0);
        chk("rerun_words", words_done, 2);

        // Start while busy is ignored.
        @(posedge clk);
        #1;
        start_test(4);
        repeat (3) @(posedge clk);
        #1 word_count = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(4, at);
        chk("busy_start_done_at", at, 3 + 4 + P);
        chk("busy_start_words", words_done, 4);

        // Start and abort together in IDLE: abort wins, nothing starts.
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        word_count = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_sa_busy", busy, 0);
        chk("idle_sa_aborted", aborted, 0);
        @(negedge clk);
        chk("idle_sa_prbs_rst", prbs_rst, 0);
        chk("idle_sa_busy2", busy, 0);
        chk("idle_sa_words", words_done, 4);

        // Reset during DRAIN.
        start_test(4);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_rst_busy", busy, 0);
        chk("drain_rst_done", done, 0);
        chk("drain_rst_aborted", aborted, 0);
        chk("drain_rst_check_enable", check_enable, 0);
        chk("drain_rst_words", words_done, 0);
        chk("drain_rst_err", err_count, 0);
        rst = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        chk("drain_rst_no_done", seen_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_test_ctrl.md
Name: lfsr_prbs_test_ctrl

Overview:
Sequencer for a PRBS link/loopback test built around lfsr_prbs_gen (transmit side) and lfsr_prbs_check (receive side).
- On a start pulse, resets both LFSRs, then enables the generator for a programmed number of words.
- Enables the checker in step with the data path latency, ignores the checker's lock-in words and accumulates the bit-error count.
- Reports busy, done, aborted and error status to a register interface or test FSM.

Parameters:
DATA_WIDTH, 64, width of the checker error vector (matches generator OUTPUT_WIDTH)
COUNT_WIDTH, 32, width of word_count and words_done
ERR_WIDTH, 32, width of the saturating bit-error counter
PIPE_LATENCY, 1, cycles from generator enable to the checker seeing that word (0..15)
LOCK_WORDS, 1, number of initial checked words excluded from error counting (checker self-sync)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle start request; ignored unless idle
abort  in  1  stop the test immediately
word_count  in  COUNT_WIDTH  number of words to generate; sampled on accepted start
prbs_rst  out  1  reset to lfsr_prbs_gen
prbs_enable  out  1  enable to lfsr_prbs_gen
check_rst  out  1  reset to lfsr_prbs_check
check_enable  out  1  enable to lfsr_prbs_check
check_err  in  DATA_WIDTH  checker error bits, valid the cycle after check_enable
busy  out  1  test in progress
done  out  1  one-cycle pulse on normal completion
aborted  out  1  sticky: last test was aborted; cleared on accepted start
err_count  out  ERR_WIDTH  saturating count of error bits in the last/current test
words_done  out  COUNT_WIDTH  generator words issued in the last/current test

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. The FSM returns to IDLE and all counters clear.

FSM states and transitions:
- IDLE: start=1 is accepted. It latches word_count, clears err_count, words_done and aborted, then goes to INIT.
- INIT: one cycle with prbs_rst=check_rst=1 and busy=1. Goes to RUN, or to DRAIN if the latched count is 0.
- RUN: prbs_enable=1 for exactly word_count cycles; words_done increments each cycle. After the last word, goes to DRAIN.
- DRAIN: lasts PIPE_LATENCY+1 cycles so the final error vectors are counted. Then goes to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.

Checker timing and error counting:
- check_enable is prbs_enable delayed by PIPE_LATENCY through a shift register. err_valid is check_enable delayed by 1.
- The first LOCK_WORDS err_valid cycles of a test are ignored.
- For each later err_valid cycle, err_count increases by popcount(check_err). The counter saturates at all-ones and never wraps.
- check_err is ignored whenever err_valid=0.

Start, abort and reset rules:
- busy is 1 in INIT, RUN and DRAIN.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins and start is ignored.
- abort in INIT, RUN or DRAIN: next cycle goes to IDLE with aborted=1 and no done pulse. prbs_enable, check_enable and the delay pipes clear. err_count and words_done hold their values.
- rst mid-test: immediate return to IDLE with all outputs 0; no done, no aborted.
- Whole-test latency: done is asserted at cycle start+2+N+PIPE_LATENCY+1, where start is the cycle the start pulse is sampled and N is word_count.

Decomposition:
- Package lfsr_prbs_test_pkg holds the state encoding (IDLE, INIT, RUN, DRAIN, DONE) and the popcount function.
- One sub-module, prbs_err_accum: valid-gated popcount adder with lock-word skip and saturation.
- Delay shift registers and the FSM stay in the top module.

Test Plan:
- Basic run: word_count=4, PIPE_LATENCY=1, check_err=0. Start sampled at cycle 0 -> prbs_rst at cycle 1, prbs_enable cycles 2-5, check_enable cycles 3-6, done at cycle 8, words_done=4, err_count=0.
- Error injection: word_count=8, LOCK_WORDS=1, check_err=64'h1 on the 1st valid cycle and 64'hFF on the 3rd -> err_count=8, because the lock word is excluded.
- Saturation: ERR_WIDTH=4, check_err all-ones for 3 counted words -> err_count=15, no wrap.
- Zero length: word_count=0 -> INIT, then DRAIN for 2 cycles, then done; prbs_enable never high; words_done=0.
- Abort mid-RUN at word 3 of 10 -> next cycle busy=0, aborted=1, no done, words_done=3. A following start clears aborted and runs normally.
- Start while busy is ignored (done timing unchanged). rst asserted during DRAIN -> all outputs 0 next cycle and no done.
